// File: rtl/lift_motion_fsm.sv
// SCAN-order lift motion and door controller: consumes registered request queues and drives
// car position, motor and door, returning one-cycle clear pulses for the floor it stops at.
module lift_motion_fsm #(
  parameter int unsigned N_FLOORS      = 8,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_up_queue,
  input  logic [N_FLOORS-1:0] i_dn_queue,
  input  logic [N_FLOORS-1:0] i_flr_queue,
  input  logic                i_door_hold,
  output logic [N_FLOORS-1:0] o_flr_pos,
  output logic                o_dir,
  output logic                o_motor_up,
  output logic                o_motor_dn,
  output logic                o_door_open,
  output logic                o_up_clr,
  output logic                o_dn_clr,
  output logic                o_flr_clr
);

  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DoorLast   = DW'(DOOR_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] One  = N_FLOORS'(1);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDn, StDoor} state_e;

  state_e              state_q, state_d;
  logic [N_FLOORS-1:0] pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                motor_up_q, motor_up_d;
  logic                motor_dn_q, motor_dn_d;
  logic                door_open_q, door_open_d;
  logic                up_clr_q, up_clr_d;
  logic                dn_clr_q, dn_clr_d;
  logic                flr_clr_q, flr_clr_d;
  logic [TW-1:0]       travel_q, travel_d;
  logic [DW-1:0]       door_cnt_q, door_cnt_d;

  // Bits strictly above the single set bit of a one-hot position.
  function automatic logic [N_FLOORS-1:0] above_mask(input logic [N_FLOORS-1:0] p);
    return ~((p << 1) - One);
  endfunction

  // Bits strictly below the single set bit of a one-hot position.
  function automatic logic [N_FLOORS-1:0] below_mask(input logic [N_FLOORS-1:0] p);
    return p - One;
  endfunction

  logic [N_FLOORS-1:0] req;
  logic [N_FLOORS-1:0] next_pos;
  logic                any_req, req_here, req_above, req_below, ahead, behind;
  logic                going_up, at_end, n_ahead, n_flr, n_hall;
  logic                enter_door, door_ahead;

  always_comb begin
    req       = i_up_queue | i_dn_queue | i_flr_queue;
    any_req   = |req;
    req_here  = |(req & pos_q);
    req_above = |(req & above_mask(pos_q));
    req_below = |(req & below_mask(pos_q));
    ahead     = dir_q ? req_above : req_below;
    behind    = dir_q ? req_below : req_above;

    // Look-ahead evaluated at the floor the car is about to reach.
    going_up = (state_q == StMoveUp);
    at_end   = going_up ? pos_q[N_FLOORS-1] : pos_q[0];
    next_pos = going_up ? (pos_q << 1) : (pos_q >> 1);
    n_ahead  = going_up ? |(req & above_mask(next_pos)) : |(req & below_mask(next_pos));
    n_flr    = |(i_flr_queue & next_pos);
    n_hall   = going_up ? |(i_up_queue & next_pos) : |(i_dn_queue & next_pos);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    motor_up_d  = motor_up_q;
    motor_dn_d  = motor_dn_q;
    door_open_d = door_open_q;
    up_clr_d    = 1'b0;
    dn_clr_d    = 1'b0;
    flr_clr_d   = 1'b0;
    travel_d    = travel_q;
    door_cnt_d  = door_cnt_q;
    enter_door  = 1'b0;
    door_ahead  = ahead;

    unique case (state_q)
      StIdle: begin
        motor_up_d  = 1'b0;
        motor_dn_d  = 1'b0;
        door_open_d = 1'b0;
        if (req_here) begin
          enter_door = 1'b1;
          door_ahead = ahead;
        end else if (ahead || behind) begin
          dir_d      = ahead ? dir_q : ~dir_q;
          state_d    = (ahead ? dir_q : ~dir_q) ? StMoveUp : StMoveDn;
          motor_up_d = ahead ? dir_q : ~dir_q;
          motor_dn_d = ahead ? ~dir_q : dir_q;
          travel_d   = '0;
        end
      end

      StMoveUp, StMoveDn: begin
        if (at_end) begin
          // Cannot travel past a terminal floor; park instead.
          state_d    = StIdle;
          motor_up_d = 1'b0;
          motor_dn_d = 1'b0;
          travel_d   = '0;
        end else if (travel_q == TravelLast) begin
          pos_d    = next_pos;
          travel_d = '0;
          if (!any_req) begin
            state_d    = StIdle;
            motor_up_d = 1'b0;
            motor_dn_d = 1'b0;
          end else if (n_flr || n_hall || !n_ahead) begin
            enter_door = 1'b1;
            door_ahead = n_ahead;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end

      StDoor: begin
        door_open_d = 1'b1;
        if (i_door_hold) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DoorLast) begin
          door_open_d = 1'b0;
          door_cnt_d  = '0;
          state_d     = StIdle;
        end else begin
          door_cnt_d = door_cnt_q + DW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    // Door entry: clear the serviced categories; reverse if nothing lies ahead.
    if (enter_door) begin
      state_d     = StDoor;
      motor_up_d  = 1'b0;
      motor_dn_d  = 1'b0;
      door_open_d = 1'b1;
      door_cnt_d  = '0;
      flr_clr_d   = 1'b1;
      up_clr_d    = dir_q || !door_ahead;
      dn_clr_d    = !dir_q || !door_ahead;
      if (!door_ahead) dir_d = ~dir_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pos_q       <= One;
      dir_q       <= 1'b1;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      door_open_q <= 1'b0;
      up_clr_q    <= 1'b0;
      dn_clr_q    <= 1'b0;
      flr_clr_q   <= 1'b0;
      travel_q    <= '0;
      door_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      motor_up_q  <= motor_up_d;
      motor_dn_q  <= motor_dn_d;
      door_open_q <= door_open_d;
      up_clr_q    <= up_clr_d;
      dn_clr_q    <= dn_clr_d;
      flr_clr_q   <= flr_clr_d;
      travel_q    <= travel_d;
      door_cnt_q  <= door_cnt_d;
    end
  end

  assign o_flr_pos   = pos_q;
  assign o_dir       = dir_q;
  assign o_motor_up  = motor_up_q;
  assign o_motor_dn  = motor_dn_q;
  assign o_door_open = door_open_q;
  assign o_up_clr    = up_clr_q;
  assign o_dn_clr    = dn_clr_q;
  assign o_flr_clr   = flr_clr_q;

endmodule
